// File: rtl/core_pkg.sv
// core_pkg: types and constants shared by the instruction-fetch slice.
//   fetch_state_t     - fetch FSM state encoding
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   NOP_INSTR_DEFAULT - default filler instruction (addi x0,x0,0)
//   is_word_aligned() - true when a byte address is a multiple of 4
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc         in  32  address of the instruction being consumed
//   pc_src     in  1   1 = branch taken (pc + imm_ext), 0 = fall through (pc + 4)
//   imm_ext    in  32  sign-extended branch offset
//   next_pc    out 32  selected successor address, modulo 2^32
//   pc_plus4   out 32  pc + 4, modulo 2^32
//   misaligned out 1   next_pc is not word aligned
module pc_next_calc
  import core_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_src,
  input  logic [31:0] imm_ext,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] pc_branch;

  // 32-bit sums: the carry out is intentionally dropped so addresses wrap.
  assign pc_plus4   = pc + 32'd4;
  assign pc_branch  = pc + imm_ext;
  assign next_pc    = pc_src ? pc_branch : pc_plus4;
  assign misaligned = ~is_word_aligned(next_pc);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding RV32I decode.
// Holds the architectural PC, issues one outstanding request at a time to
// instruction memory, latches the returned word and hands it to decode with
// a valid/stall handshake. Supports flush/redirect and flags misaligned
// fetch targets with a sticky fault.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ready        request channel (addr word aligned)
//   imem_rvalid/rdata          response channel
//   Instr, PC, PCPlus4         held instruction and its address to decode
//   instr_valid, stall         decode handshake (consume = valid & ~stall)
//   PCSrc, ImmExt              branch decision/offset for the consumed instr
//   flush, flush_pc            restart fetch at flush_pc (highest priority)
//   fetch_fault                sticky misaligned-target flag
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_fault
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  instr_reg, instr_next;
  logic         instr_valid_reg, instr_valid_next;
  logic         fault_reg, fault_next;
  // Set while a response belonging to a flushed request is still due; that
  // response is swallowed instead of being latched.
  logic         drain_reg, drain_next;

  logic [31:0]  calc_next_pc;
  logic [31:0]  calc_pc_plus4;
  logic         calc_misaligned;
  logic         accept;
  logic         consume;

  pc_next_calc u_pc_next_calc (
    .pc         (pc_reg),
    .pc_src     (PCSrc),
    .imm_ext    (ImmExt),
    .next_pc    (calc_next_pc),
    .pc_plus4   (calc_pc_plus4),
    .misaligned (calc_misaligned)
  );

  assign accept  = (state_reg == ST_REQ) && imem_ready;
  assign consume = instr_valid_reg && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      fetch_pc_reg    <= RESET_PC;
      pc_reg          <= RESET_PC;
      instr_reg       <= NOP_INSTR;
      instr_valid_reg <= 1'b0;
      fault_reg       <= 1'b0;
      drain_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      pc_reg          <= pc_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
      fault_reg       <= fault_next;
      drain_reg       <= drain_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    pc_next          = pc_reg;
    instr_next       = instr_reg;
    instr_valid_next = instr_valid_reg;
    fault_next       = fault_reg;
    drain_next       = drain_reg;

    if (flush) begin
      instr_valid_next = 1'b0;
      instr_next       = NOP_INSTR;
      fetch_pc_next    = flush_pc;
      // A request is still in flight if we are waiting without its response
      // arriving now, if one is accepted this very cycle, or if a drained
      // response is still owed while parked in FAULT.
      drain_next = ((state_reg == ST_WAIT) && !imem_rvalid) ||
                   accept ||
                   ((state_reg == ST_FAULT) && drain_reg && !imem_rvalid);
      if (!is_word_aligned(flush_pc)) begin
        fault_next = 1'b1;
        state_next = ST_FAULT;
      end else begin
        fault_next = 1'b0;
        state_next = drain_next ? ST_WAIT : ST_REQ;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_REQ;
        end
        ST_REQ: begin
          if (imem_ready) begin
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drain_reg) begin
              drain_next = 1'b0;
              state_next = ST_REQ;
            end else begin
              instr_next       = imem_rdata;
              pc_next          = fetch_pc_reg;
              instr_valid_next = 1'b1;
              state_next       = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (consume) begin
            instr_valid_next = 1'b0;
            instr_next       = NOP_INSTR;
            if (calc_misaligned) begin
              fault_next = 1'b1;
              state_next = ST_FAULT;
            end else begin
              fetch_pc_next = calc_next_pc;
              state_next    = ST_REQ;
            end
          end
        end
        ST_FAULT: begin
          // Only a flush or reset leaves FAULT; just retire a stale response.
          if (drain_reg && imem_rvalid) begin
            drain_next = 1'b0;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (state_reg == ST_REQ);
  assign imem_addr   = fetch_pc_reg;
  // instr_reg is forced to NOP whenever no valid instruction is held.
  assign Instr       = instr_reg;
  assign PC          = pc_reg;
  assign PCPlus4     = calc_pc_plus4;
  assign instr_valid = instr_valid_reg;
  assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        stall;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_fault;

  // Directed drivers (d_*) and random memory responder (m_*) share the bus.
  logic        mem_en;
  logic        d_ready, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  assign imem_ready  = mem_en ? m_ready  : d_ready;
  assign imem_rvalid = mem_en ? m_rvalid : d_rvalid;
  assign imem_rdata  = mem_en ? m_rdata  : d_rdata;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instr_valid (instr_valid),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h1357, a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  // Random memory responder: random ready, response 1..3 cycles after accept.
  initial begin
    logic        pending;
    logic [31:0] resp;
    int          dly;
    pending = 1'b0; resp = '0; dly = 0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(negedge clk);
      m_rvalid = 1'b0;
      if (!mem_en) begin
        pending = 1'b0;
        m_ready = 1'b0;
      end else begin
        if (pending) begin
          if (dly == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = resp;
            pending  = 1'b0;
          end else begin
            dly--;
          end
        end
        m_ready = ($urandom % 4) != 0;
        if (imem_req && m_ready) begin
          pending = 1'b1;
          resp    = mem_word(imem_addr);
          dly     = $urandom % 3;
        end
      end
    end
  end

  // Stimulus helpers (no checking inside).
  task automatic serve(input logic [31:0] data, output logic [31:0] addr, output bit ok);
    ok = 1'b0;
    addr = '0;
    d_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        addr = imem_addr;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      d_ready = 1'b0;
      return;
    end
    @(negedge clk);
    d_ready = 1'b0;
    d_rvalid = 1'b1;
    d_rdata = data;
    @(negedge clk);
    d_rvalid = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] a);
    flush = 1'b1;
    flush_pc = a;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic consume(input logic src, input logic [31:0] imm);
    stall = 1'b0;
    PCSrc = src;
    ImmExt = imm;
    @(negedge clk);
    stall = 1'b1;
    PCSrc = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] exp_addr [3];
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    total++; if (Instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", Instr, NOP); end
    total++; if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_flags: valid=%b fault=%b want 0 0", instr_valid, fetch_fault); end
    // first fetch: ready=1, response one cycle after accept
    rst_n = 1'b1;
    d_ready = 1'b1;
    exp_addr[0] = 32'h0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== exp_addr[0]) begin bad++; $display("FAIL first_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_addr[0]); end
    @(negedge clk);
    d_ready = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL first_wait: req=%b valid=%b want 0 0", imem_req, instr_valid); end
    d_rvalid = 1'b1;
    d_rdata = 32'h0050_0093;
    @(negedge clk);
    d_rvalid = 1'b0;
    total++; if (instr_valid !== 1'b1 || Instr !== 32'h0050_0093) begin bad++; $display("FAIL first_instr: valid=%b instr=%h want 1 00500093", instr_valid, Instr); end
    total++; if (PC !== 32'h0 || PCPlus4 !== 32'h4) begin bad++; $display("FAIL first_pc: pc=%h pc4=%h want 0 4", PC, PCPlus4); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    bit ok;
    do_flush(32'hFFFF_FFFC);
    total++; if (instr_valid !== 1'b0 || Instr !== NOP) begin bad++; $display("FAIL flush_clear: valid=%b instr=%h want 0 %h", instr_valid, Instr, NOP); end
    serve(32'h1111_2222, a, ok);
    total++; if (!ok || a !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req: ok=%b addr=%h want 1 fffffffc", ok, a); end
    total++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4: pc=%h pc4=%h want fffffffc 0", PC, PCPlus4); end
    consume(1'b0, 32'h0000_1234);
    serve(32'h3333_4444, a, ok);
    total++; if (!ok || a !== 32'h0) begin bad++; $display("FAIL wrap_next: ok=%b addr=%h want 1 0", ok, a); end
    total++; if (Instr !== 32'h3333_4444 || PC !== 32'h0) begin bad++; $display("FAIL wrap_instr: instr=%h pc=%h want 33334444 0", Instr, PC); end
  endtask

  task automatic test_branch_stall;
    logic [31:0] a;
    bit ok;
    do_flush(32'h100);
    serve(32'h5555_6666, a, ok);
    total++; if (!ok || a !== 32'h100) begin bad++; $display("FAIL br_req: ok=%b addr=%h want 1 100", ok, a); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (Instr !== 32'h5555_6666 || PC !== 32'h100 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold: instr=%h pc=%h valid=%b req=%b want 55556666 100 1 0", Instr, PC, instr_valid, imem_req);
      end
    end
    consume(1'b1, 32'hFFFF_FFF0);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin bad++; $display("FAIL br_target: req=%b addr=%h want 1 f0", imem_req, imem_addr); end
    serve(32'h7777_8888, a, ok);
    total++; if (instr_valid !== 1'b1 || PC !== 32'hF0) begin bad++; $display("FAIL br_instr: valid=%b pc=%h want 1 f0", instr_valid, PC); end
  endtask

  task automatic test_fault_flush;
    logic [31:0] a;
    bit ok;
    do_flush(32'h20);
    serve(32'h0000_0063, a, ok);
    consume(1'b1, 32'h6);
    total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL fault_set: fault=%b req=%b want 1 0", fetch_fault, imem_req); end
    total++; if (instr_valid !== 1'b0 || Instr !== NOP) begin bad++; $display("FAIL fault_nop: valid=%b instr=%h want 0 %h", instr_valid, Instr, NOP); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_stay: req=%b fault=%b want 0 1", imem_req, fetch_fault); end
    end
    do_flush(32'h42);
    total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL flush_misalign: fault=%b req=%b want 1 0", fetch_fault, imem_req); end
    do_flush(32'h40);
    total++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL fault_clear: fault=%b req=%b addr=%h want 0 1 40", fetch_fault, imem_req, imem_addr);
    end
    serve(32'h0040_0093, a, ok);
    total++; if (!ok || Instr !== 32'h0040_0093 || PC !== 32'h40) begin bad++; $display("FAIL fault_resume: instr=%h pc=%h want 00400093 40", Instr, PC); end
  endtask

  task automatic test_flush_drain;
    logic [31:0] a;
    bit ok;
    do_flush(32'h60);
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h80;
    @(negedge clk);
    flush = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL drain_wait: req=%b valid=%b want 0 0", imem_req, instr_valid); end
    d_rvalid = 1'b1;
    d_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    d_rvalid = 1'b0;
    total++; if (instr_valid !== 1'b0 || Instr === 32'hDEAD_BEEF) begin bad++; $display("FAIL drain_drop: valid=%b instr=%h want 0 %h", instr_valid, Instr, NOP); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin bad++; $display("FAIL drain_rereq: req=%b addr=%h want 1 80", imem_req, imem_addr); end
    serve(32'h00A0_0113, a, ok);
    total++; if (!ok || a !== 32'h80 || Instr !== 32'h00A0_0113 || PC !== 32'h80) begin
      bad++; $display("FAIL drain_resume: addr=%h instr=%h pc=%h want 80 00a00113 80", a, Instr, PC);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] a;
    bit ok;
    do_flush(32'h200);
    serve(32'h0000_0093, a, ok);
    consume(1'b0, 32'h0);
    d_ready = 1'b1;
    @(negedge clk);
    d_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || PC !== 32'h0) begin
      bad++; $display("FAIL async_rst_addr: req=%b addr=%h pc=%h want 0 0 0", imem_req, imem_addr, PC);
    end
    total++; if (Instr !== NOP || instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL async_rst_out: instr=%h valid=%b fault=%b want %h 0 0", Instr, instr_valid, fetch_fault, NOP);
    end
    @(negedge clk);
    d_rvalid = 1'b1;
    d_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d_rvalid = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL late_rvalid: valid=%b req=%b addr=%h want 0 1 0", instr_valid, imem_req, imem_addr);
    end
    serve(32'h00C0_0193, a, ok);
    total++; if (!ok || a !== 32'h0 || Instr !== 32'h00C0_0193 || PC !== 32'h0) begin
      bad++; $display("FAIL restart: addr=%h instr=%h pc=%h want 0 00c00193 0", a, Instr, PC);
    end
  endtask

  // Random run against a reference that only tracks "which address must be
  // fetched/presented next" and memory contents.
  task automatic test_random;
    logic [31:0] exp_pc, imm, nxt;
    int consumed, cyc;
    bit fault_exp, post_flush;
    consumed = 0; cyc = 0; fault_exp = 0; post_flush = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    exp_pc = 32'h0;
    while (consumed < 60 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      stall = 1'b1;
      if (imem_req) begin
        total++; if (imem_addr !== exp_pc) begin bad++; $display("FAIL rnd_addr: got %h want %h", imem_addr, exp_pc); end
      end
      if (post_flush) begin
        post_flush = 0;
        total++; if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin bad++; $display("FAIL rnd_flush: valid=%b fault=%b want 0 0", instr_valid, fetch_fault); end
      end
      if (fault_exp || ($urandom % 20 == 0)) begin
        if (fault_exp) begin
          total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL rnd_fault: fault=%b req=%b want 1 0", fetch_fault, imem_req); end
          fault_exp = 0;
        end
        flush = 1'b1;
        flush_pc = $urandom & 32'hFFFF_FFFC;
        exp_pc = flush_pc;
        post_flush = 1;
        continue;
      end
      if (instr_valid) begin
        stall = ($urandom % 3) == 0;
        if (!stall) begin
          total++; if (Instr !== mem_word(exp_pc) || PC !== exp_pc || PCPlus4 !== exp_pc + 32'd4) begin
            bad++; $display("FAIL rnd_instr: instr=%h pc=%h pc4=%h want %h %h %h", Instr, PC, PCPlus4, mem_word(exp_pc), exp_pc, exp_pc + 32'd4);
          end
          imm = $urandom & 32'hFFFF_FFFC;
          if ($urandom % 6 == 0) imm[1:0] = 2'b10;
          PCSrc = ($urandom % 2) == 1;
          ImmExt = imm;
          nxt = PCSrc ? exp_pc + imm : exp_pc + 32'd4;
          consumed++;
          if (nxt[1:0] != 2'b00) fault_exp = 1;
          else exp_pc = nxt;
        end
      end
    end
    total++; if (consumed < 60) begin bad++; $display("FAIL rnd_budget: consumed %0d want 60", consumed); end
    mem_en = 1'b0;
    stall = 1'b1;
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_en = 1'b0;
    d_ready = 1'b0;
    d_rvalid = 1'b0;
    d_rdata = '0;
    stall = 1'b1;
    PCSrc = 1'b0;
    ImmExt = '0;
    flush = 1'b0;
    flush_pc = '0;
    test_reset();
    test_wrap();
    test_branch_stall();
    test_fault_flush();
    test_flush_drain();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode/control logic of the single-cycle RV32I core. Holds the architectural PC and issues one-outstanding requests to instruction memory over a req/ready, rvalid handshake. Latches the returned word into an instruction register and presents Instr/PC/PCPlus4 to decode with a valid/stall handshake. Computes the next PC from the consumer's PCSrc and ImmExt, and supports an external flush/redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on Instr when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address, word aligned
imem_ready  in  1  memory accepts request this cycle when imem_req=1
imem_rvalid  in  1  read data valid, at least 1 cycle after acceptance
imem_rdata  in  32  returned instruction word
Instr  out  32  held instruction; op/funct3/funct7_5 are sliced from it downstream
PC  out  32  address of Instr
PCPlus4  out  32  PC+4, modulo 2^32
instr_valid  out  1  Instr/PC are valid
stall  in  1  downstream not consuming this cycle
PCSrc  in  1  branch taken for the consumed instruction
ImmExt  in  32  sign-extended branch offset for the consumed instruction
flush  in  1  discard current state and restart at flush_pc
flush_pc  in  32  restart address
fetch_fault  out  1  misaligned fetch target detected; sticky

Behaviour:
- Reset (async, rst_n=0): state=IDLE; fetch_pc=RESET_PC; PC=RESET_PC; Instr=NOP_INSTR; imem_req=0; imem_addr=RESET_PC; instr_valid=0; fetch_fault=0. Any outstanding transaction is abandoned. An rvalid seen while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ:
  - imem_req=1, imem_addr=fetch_pc, held stable until imem_ready.
  - On req&ready -> WAIT.
- WAIT:
  - imem_req=0.
  - On imem_rvalid: Instr<=imem_rdata, PC<=fetch_pc, instr_valid<=1, -> HOLD.
- HOLD:
  - Instr/PC held while stall=1.
  - Consume = instr_valid & ~stall. On consume: next = PCSrc ? PC+ImmExt : PC+4 (32-bit wrap, carry discarded); instr_valid<=0.
  - If next[1:0]!=0: fetch_fault<=1, -> FAULT. Otherwise fetch_pc<=next, -> REQ.
- FAULT:
  - No requests, instr_valid=0, Instr=NOP_INSTR.
  - Leaves only via flush or reset.
- Latency: reset release to first instr_valid is 3 cycles minimum (ready=1, rvalid 1 cycle after accept). Consume to next instr_valid is 3 cycles minimum.
- flush (highest priority, any state):
  - Next cycle: fetch_pc=flush_pc, instr_valid=0, Instr=NOP_INSTR, fetch_fault=0.
  - If a request is outstanding (WAIT, or REQ accepted this cycle), enter DRAIN sub-flag: the next imem_rvalid is discarded, then -> REQ. Otherwise -> REQ directly.
  - flush_pc misaligned: fetch_fault=1, -> FAULT.
- flush together with consume: flush wins; PCSrc is ignored.
- flush during REQ not yet accepted: imem_addr changes to flush_pc next cycle. This is the only case where an unaccepted request's address may change.
- Only one request outstanding at any time. imem_req=0 in WAIT, HOLD, IDLE and FAULT.

Decomposition:
- Shared package core_pkg holds the fetch state enum, NOP_INSTR and the RESET_PC default.
- One sub-module, pc_next_calc, is natural: combinational PC+4 / PC+ImmExt select plus the alignment check.
- Everything else stays in fetch_unit.

Test Plan:
1. Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h00500093 -> imem_addr=0 cycle 1, instr_valid=1 cycle 3, Instr=32'h00500093, PC=0, PCPlus4=4.
2. Consume with PCSrc=0 at PC=32'hFFFF_FFFC -> next imem_addr=32'h0000_0000 (wrap).
3. PC=32'h100, PCSrc=1, ImmExt=32'hFFFF_FFF0 -> imem_addr=32'hF0. stall=1 for 4 cycles before this -> Instr/PC stable, no request issued.
4. PCSrc=1, ImmExt=32'h6 at PC=32'h20 -> fetch_fault=1, imem_req stays 0. Then flush, flush_pc=32'h40 -> fault clears, imem_addr=32'h40.
5. flush (flush_pc=32'h80) while in WAIT -> stale rvalid (rdata=32'hDEADBEEF) is dropped, and a new request to 32'h80 follows. Instr never equals 32'hDEADBEEF with instr_valid=1.
6. rst_n low mid-WAIT -> outputs return to their reset values immediately, without waiting for a clock edge; late rvalid is ignored; fetch restarts at RESET_PC.
